// File: rtl/flush_ctrl.sv
// flush_ctrl: sequences pipeline flush and fetch redirection on exceptions
// and ERET signalled by the write-back stage.
//
// When the write-back stage raises ws_ex or eret_flush while the block is
// IDLE, it pulses flush for one cycle and latches the redirect target
// (EX_ENTRY for exceptions, cp0_epc for ERET). Any instruction requests still
// outstanding at that point are stale. Their returning data is marked for
// discard (DRAIN state). After that, the target is presented to pre-IF until
// pre-IF accepts it (REDIRECT state).
//
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   ws_ex           - valid exception in WB
//   eret_flush      - valid ERET in WB
//   cp0_epc         - current CP0 EPC
//   inst_req        - pre-IF instruction request
//   inst_addr_ok    - inst bus accepted an address
//   inst_data_ok    - inst bus returned data
//   inst_req_block  - pre-IF must not raise inst_req
//   flush           - clear valid in all pipeline stages
//   discard_data    - fetch stage must drop this cycle's returned data
//   redirect_valid  - redirect_pc is valid for pre-IF
//   redirect_pc     - next fetch PC after the flush
//   redirect_ready  - pre-IF accepted the redirect
//   busy            - sequencer is in DRAIN or REDIRECT
module flush_ctrl #(
    parameter logic [31:0] EX_ENTRY        = 32'hbfc00380,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_ex,
    input  logic        eret_flush,
    input  logic [31:0] cp0_epc,
    input  logic        inst_req,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic        inst_req_block,
    output logic        flush,
    output logic        discard_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        REDIRECT
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   out_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   drain_cnt, drain_nxt;
    logic [31:0]        target, target_nxt;
    logic               accept;
    logic               data_eff;
    logic               trig;

    assign accept   = inst_req && inst_addr_ok;
    // A data_ok with nothing outstanding is ignored so the counter never wraps.
    // When it coincides with an accept, that accept supplies the request.
    assign data_eff = inst_data_ok && ((out_cnt != '0) || accept);
    assign cnt_nxt  = out_cnt + CNT_W'(accept) - CNT_W'(data_eff);
    assign trig     = ws_ex || eret_flush;

    assign inst_req_block = (out_cnt == CNT_W'(MAX_OUTSTANDING))
                          || (state == DRAIN) || (state == REDIRECT);
    assign busy           = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        drain_nxt    = drain_cnt;
        target_nxt   = target;
        flush        = 1'b0;
        discard_data = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    flush      = 1'b1;
                    target_nxt = ws_ex ? EX_ENTRY : cp0_epc;
                    // Requests accepted up to and including this cycle are stale.
                    drain_nxt  = cnt_nxt;
                    state_nxt  = (cnt_nxt == '0) ? REDIRECT : DRAIN;
                end
            end
            DRAIN: begin
                // Accepts seen here are not added to drain_cnt.
                if (inst_data_ok) begin
                    discard_data = 1'b1;
                    drain_nxt    = drain_cnt - 1'b1;
                    if (drain_cnt <= CNT_W'(1)) begin
                        state_nxt = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            out_cnt        <= '0;
            drain_cnt      <= '0;
            target         <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_nxt;
            out_cnt        <= cnt_nxt;
            drain_cnt      <= drain_nxt;
            target         <= target_nxt;
            // The redirect outputs follow the next state. This registers them
            // and keeps them aligned with the REDIRECT state.
            redirect_valid <= (state_nxt == REDIRECT);
            redirect_pc    <= (state_nxt == REDIRECT) ? target_nxt : '0;
        end
    end

endmodule

// File: doc/flush_ctrl.md
Name: flush_ctrl

Overview:
Sequences pipeline flush and fetch redirection for exceptions and ERET signalled by the write-back stage.
- Pulses a flush to all stages.
- Drains instruction-side requests that are still outstanding, and marks their returning data for discard.
- Presents the redirect PC to pre-IF: the exception entry, or CP0 EPC for ERET.
- Also tracks the outstanding inst-request count and throttles new requests.

Parameters:
EX_ENTRY, 32'hbfc00380, exception handler entry PC
MAX_OUTSTANDING, 4, max inst requests accepted but not yet returned
CNT_W, 3, counter width; must hold MAX_OUTSTANDING

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ws_ex  in  1  valid exception in WB (already qualified by ws_valid)
eret_flush  in  1  valid ERET in WB (already qualified by ws_valid)
cp0_epc  in  32  current CP0 EPC
inst_req  in  1  pre-IF instruction request
inst_addr_ok  in  1  inst bus accepted address
inst_data_ok  in  1  inst bus returned data
inst_req_block  out  1  pre-IF must not raise inst_req
flush  out  1  clear valid in all pipeline stages
discard_data  out  1  fetch stage must drop this cycle's returned data
redirect_valid  out  1  redirect_pc is valid for pre-IF
redirect_pc  out  32  next fetch PC after flush
redirect_ready  in  1  pre-IF accepted redirect
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset state:
  - state=IDLE, out_cnt=0, drain_cnt=0.
  - All outputs 0; redirect_pc=0.
  - A reset mid-operation abandons any drain or redirect.
- Outstanding counter out_cnt (CNT_W bits):
  - +1 on inst_req&&inst_addr_ok; -1 on inst_data_ok; both in the same cycle leaves it unchanged.
  - Never wraps: data_ok with out_cnt==0 and no accept is ignored, and the counter stays 0.
  - inst_req_block = (out_cnt==MAX_OUTSTANDING) || state==DRAIN || state==REDIRECT. Combinational.
- Define cnt_nxt = the post-update value of out_cnt for the current cycle.
- Trigger, IDLE only: trig = ws_ex || eret_flush.
  - flush=1, combinational, in the trigger cycle only.
  - Target latched at the clock edge: ws_ex has priority, target EX_ENTRY; eret_flush alone, target cp0_epc sampled in that cycle.
  - Every request accepted at or before the trigger cycle is stale. drain_cnt <= cnt_nxt.
  - If cnt_nxt==0, next state is REDIRECT; otherwise DRAIN.
- DRAIN:
  - Each inst_data_ok gives discard_data=1 (combinational) and drain_cnt-1.
  - When inst_data_ok arrives with drain_cnt==1, next state is REDIRECT.
  - inst_req&&inst_addr_ok in DRAIN is a protocol violation: it is not counted into drain_cnt, but still updates out_cnt.
- REDIRECT:
  - redirect_valid=1 and redirect_pc=latched target, both registered.
  - Held stable until redirect_ready=1; at that edge the next state is IDLE, and redirect_valid and redirect_pc clear the next cycle.
  - discard_data=0 in this state.
- ws_ex or eret_flush while not IDLE: ignored. No second flush pulse; the target is unchanged.
- In IDLE, discard_data=0, redirect_valid=0, flush=trig.
- busy=1 in DRAIN and REDIRECT.
- Latency: flush in cycle T. redirect_valid first appears at T+1 when nothing is outstanding; otherwise one cycle after the last stale data_ok.

Test Plan:
1. Reset, then ws_ex=1 for one cycle with out_cnt=0.
   - Required: flush=1 at T; redirect_valid=1 and redirect_pc=32'hbfc00380 at T+1.
   - With redirect_ready=1 at T+1: busy=0 at T+2.
2. Two requests accepted (out_cnt=2), then eret_flush=1 with cp0_epc=32'hbfc00100.
   - Required: state DRAIN; inst_req_block=1.
   - data_ok at T+2 and T+4: discard_data=1 on exactly those cycles.
   - redirect_valid=1 with PC 32'hbfc00100 at T+5.
3. ws_ex=1 and eret_flush=1 in the same cycle, with cp0_epc=32'h12345678.
   - Required: redirect_pc=32'hbfc00380.
4. Trigger cycle also has inst_req&&inst_addr_ok, with out_cnt=1 beforehand.
   - Required: drain_cnt=2; two discard_data pulses before redirect.
   - Second variant, same cycle has data_ok and accept with out_cnt=1: drain_cnt=1.
5. Throttle: four accepts without data_ok.
   - Required: inst_req_block=1 at out_cnt=4.
   - One data_ok: block drops the next cycle.
   - data_ok at out_cnt=0 with no accept: counter stays 0.
6. Second ws_ex during DRAIN: no flush pulse and target unchanged.
   - reset=1 during REDIRECT with redirect_ready=0: next cycle redirect_valid=0, busy=0, out_cnt=0.
